accum_unit: RTL and testbench
=============================

// Module: accum_unit
// PURPOSE
//  Registered accumulator stage that sits directly downstream of the parametric adder.
//  Consumes the adder's sum and carry outputs one sample per valid/ready handshake.
//  Sums COUNT samples into an ACC_WIDTH register, then presents the frame result
//  with valid/ready output handshake and a sticky overflow flag.
// PARAMETERS
//  WIDTH      4  width of the adder sum input (sample = {c_in, sum_in}, WIDTH+1 bits)
//  COUNT      4  samples per frame; legal range >= 1
//  ACC_WIDTH  8  accumulator/result width; must be >= WIDTH+1
// PORTS
//  clk_in     in   1                     clock, all logic on rising edge
//  rst_n_in   in   1                     synchronous reset, active-low
//  clr_in     in   1                     synchronous frame abort/clear, active-high
//  sum_in     in   WIDTH                 adder sum (q_out of adder)
//  c_in       in   1                     adder carry (c_out of adder)
//  valid_in   in   1                     sample valid
//  ready_out  out  1                     stage can accept a sample
//  acc_out    out  ACC_WIDTH             accumulated frame result
//  valid_out  out  1                     acc_out holds a completed frame
//  ready_in   in   1                     consumer accepts result
//  ovf_out    out  1                     sticky overflow for current frame
//  cnt_out    out  $clog2(COUNT+1)       samples accepted in current frame
// BEHAVIOUR
//  - Reset (rst_n_in=0 at edge): state=IDLE, acc_out=0, valid_out=0, ovf_out=0, cnt_out=0.
//    ready_out = (state!=DONE) & rst_n_in, so ready_out=0 while reset is asserted.
//  - Priority: rst_n_in > clr_in > handshakes. clr_in: next cycle IDLE, acc/cnt/ovf=0,
//    any in-progress or pending frame is discarded; a sample offered that cycle is dropped.
//  - Sample accept: valid_in & ready_out. Sample = {c_in,sum_in} zero-extended to ACC_WIDTH.
//  - FSM: IDLE  : ready_out=1; accept -> acc=sample, cnt=1; -> ACCUM (-> DONE if COUNT==1).
//         ACCUM : ready_out=1; accept -> acc+=sample, cnt+=1; -> DONE when cnt reaches COUNT.
//         DONE  : ready_out=0, valid_out=1, acc_out/ovf_out/cnt_out held stable;
//                 ready_in=1 -> next cycle IDLE, valid_out=0, acc=0, cnt=0, ovf=0.
//  - Latency: valid_out rises the cycle after the COUNT-th accept. One bubble cycle
//    (IDLE) between frames; valid_in ignored in DONE.
//  - Gaps: valid_in low in ACCUM holds acc/cnt unchanged, no timeout.
//  - Arithmetic: unsigned ACC_WIDTH add; carry out of MSB sets ovf_out (sticky to frame end).
//  - valid_out is registered; acc_out never changes while valid_out=1 and ready_in=0.
// CONFIGURATION
//  ACCUM_SATURATE_EN defined: on carry out of MSB acc clamps to all-ones and stays there
//    for the rest of the frame; ovf_out=1.
//  ACCUM_SATURATE_EN undefined: acc wraps modulo 2^ACC_WIDTH; ovf_out=1.
// TESTING (WIDTH=4, COUNT=4, ACC_WIDTH=8 unless stated)
//  1 Reset: rst_n_in=0 two cycles -> acc_out=0, valid_out=0, ovf_out=0, cnt_out=0,
//    ready_out=0; release -> ready_out=1 next cycle.
//  2 Frame: back-to-back {c,sum}=0x03,0x05,0x1F,0x01 -> valid_out=1 one cycle after 4th
//    accept, acc_out=0x28, ovf_out=0, cnt_out=4.
//  3 Backpressure: ready_in=0 for 5 cycles in DONE -> acc_out=0x28 stable, ready_out=0,
//    valid_in pulses ignored; ready_in=1 -> next cycle valid_out=0, acc_out=0, ready_out=1.
//  4 Overflow (ACC_WIDTH=6): 4 x 0x1F -> wrap build acc_out=0x3C, ovf_out=1;
//    ACCUM_SATURATE_EN build acc_out=0x3F, ovf_out=1; next frame starts with ovf_out=0.
//  5 clr_in after 2 samples (0x03,0x05) -> next cycle acc_out=0, cnt_out=0, IDLE;
//    following frame 4 x 0x02 -> acc_out=0x08.
//  6 Gapped valid_in (1,0,0,1,0,1,1) with samples 0x01 -> result only after 4th accept,
//    acc_out=0x04; rst_n_in=0 mid-frame -> all outputs to reset values next cycle.

Source files
------------

// File: rtl/accum_unit.sv
// accum_unit: registered frame accumulator downstream of the parametric adder.
// Accepts {c_in, sum_in} samples over a valid/ready handshake, sums COUNT of
// them into an ACC_WIDTH register and presents the result with valid/ready and
// a sticky overflow flag.
// Build option: define ACCUM_SATURATE_EN to clamp the accumulator to all-ones
// on overflow; otherwise it wraps modulo 2^ACC_WIDTH.
module accum_unit #(
    parameter int WIDTH     = 4,
    parameter int COUNT     = 4,
    parameter int ACC_WIDTH = 8
) (
    input  logic                         clk_in,
    input  logic                         rst_n_in,
    input  logic                         clr_in,
    input  logic [WIDTH-1:0]             sum_in,
    input  logic                         c_in,
    input  logic                         valid_in,
    output logic                         ready_out,
    output logic [ACC_WIDTH-1:0]         acc_out,
    output logic                         valid_out,
    input  logic                         ready_in,
    output logic                         ovf_out,
    output logic [$clog2(COUNT+1)-1:0]   cnt_out
);

    localparam int CNT_W = $clog2(COUNT + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCUM,
        S_DONE
    } state_t;

    state_t               state;
    state_t               state_nx;
    logic [ACC_WIDTH-1:0] acc;
    logic [ACC_WIDTH-1:0] acc_nx;
    logic [CNT_W-1:0]     cnt;
    logic [CNT_W-1:0]     cnt_nx;
    logic                 ovf;
    logic                 ovf_nx;
    logic                 accept;
    logic [ACC_WIDTH-1:0] sample;
    logic [ACC_WIDTH-1:0] base;
    logic [ACC_WIDTH:0]   sum_ext;

    // State register
    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic: clear aborts any frame, DONE waits for the consumer
    always_comb begin
        state_nx = state;
        if (clr_in) begin
            state_nx = S_IDLE;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        state_nx = (COUNT == 1) ? S_DONE : S_ACCUM;
                    end
                end
                S_ACCUM: begin
                    if (accept && (cnt == CNT_W'(COUNT - 1))) begin
                        state_nx = S_DONE;
                    end
                end
                S_DONE: begin
                    if (ready_in) begin
                        state_nx = S_IDLE;
                    end
                end
                default: state_nx = S_IDLE;
            endcase
        end
    end

    // Outputs: handshake flags from state, result straight from the registers
    always_comb begin
        ready_out = (state != S_DONE) & rst_n_in;
        valid_out = (state == S_DONE);
        accept    = valid_in & ready_out;
        acc_out   = acc;
        ovf_out   = ovf;
        cnt_out   = cnt;
    end

    // Datapath next values: sample add with carry-out capture
    always_comb begin
        sample              = '0;
        sample[WIDTH:0]     = {c_in, sum_in};
        // IDLE starts a fresh frame, so the old accumulator is not an addend
        base                = (state == S_IDLE) ? '0 : acc;
        sum_ext             = {1'b0, base} + {1'b0, sample};
        acc_nx              = acc;
        cnt_nx              = cnt;
        ovf_nx              = ovf;
        if (clr_in) begin
            acc_nx = '0;
            cnt_nx = '0;
            ovf_nx = 1'b0;
        end else if (state == S_DONE) begin
            if (ready_in) begin
                acc_nx = '0;
                cnt_nx = '0;
                ovf_nx = 1'b0;
            end
        end else if (accept) begin
            cnt_nx = (state == S_IDLE) ? CNT_W'(1) : cnt + CNT_W'(1);
            ovf_nx = ((state == S_ACCUM) & ovf) | sum_ext[ACC_WIDTH];
`ifdef ACCUM_SATURATE_EN
            // Once clamped, the accumulator stays at all-ones until frame end
            if (sum_ext[ACC_WIDTH] || ((state == S_ACCUM) && ovf)) begin
                acc_nx = '1;
            end else begin
                acc_nx = sum_ext[ACC_WIDTH-1:0];
            end
`else
            acc_nx = sum_ext[ACC_WIDTH-1:0];
`endif
        end
    end

    // Datapath registers
    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            acc <= '0;
            cnt <= '0;
            ovf <= 1'b0;
        end else begin
            acc <= acc_nx;
            cnt <= cnt_nx;
            ovf <= ovf_nx;
        end
    end

endmodule

// File: tb/tb_accum_unit.sv
// tb_accum_unit: self-checking bench for accum_unit.
// Two instances (ACC_WIDTH=8 and ACC_WIDTH=6) share the same stimulus; a
// frame-level model (running integer sum, sample count) predicts both.
module tb_accum_unit;

    localparam int WIDTH = 4;
    localparam int COUNT = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       clr;
    logic [3:0] sum_v;
    logic       c_v;
    logic       valid_i;
    logic       rdy_i;

    logic       ready8, valid8, ovf8;
    logic [7:0] acc8;
    logic [2:0] cnt8;
    logic       ready6, valid6, ovf6;
    logic [5:0] acc6;
    logic [2:0] cnt6;

    int n_tests = 0;
    int n_fail  = 0;

    // Model state
    bit     m_done = 1'b0;
    int     m_cnt  = 0;
    longint m_sum  = 0;

    always #5 clk = ~clk;

    accum_unit #(.WIDTH(WIDTH), .COUNT(COUNT), .ACC_WIDTH(8)) dut8 (
        .clk_in(clk), .rst_n_in(rst_n), .clr_in(clr), .sum_in(sum_v), .c_in(c_v),
        .valid_in(valid_i), .ready_out(ready8), .acc_out(acc8), .valid_out(valid8),
        .ready_in(rdy_i), .ovf_out(ovf8), .cnt_out(cnt8)
    );

    accum_unit #(.WIDTH(WIDTH), .COUNT(COUNT), .ACC_WIDTH(6)) dut6 (
        .clk_in(clk), .rst_n_in(rst_n), .clr_in(clr), .sum_in(sum_v), .c_in(c_v),
        .valid_in(valid_i), .ready_out(ready6), .acc_out(acc6), .valid_out(valid6),
        .ready_in(rdy_i), .ovf_out(ovf6), .cnt_out(cnt6)
    );

    typedef struct {
        logic       rst_n;
        logic       clr;
        logic       valid;
        logic [4:0] smp;
        logic       rdy;
        logic       e_valid;
        logic [7:0] e_acc;
        logic       e_ovf;
        logic [2:0] e_cnt;
        logic       e_ready;
    } vec_t;

    vec_t vt[13];

    function automatic vec_t mk(logic r, logic cl, logic v, logic [4:0] s, logic ri,
                                logic ev, logic [7:0] ea, logic eo, logic [2:0] ec, logic er);
        vec_t x;
        x.rst_n = r;  x.clr = cl; x.valid = v; x.smp = s; x.rdy = ri;
        x.e_valid = ev; x.e_acc = ea; x.e_ovf = eo; x.e_cnt = ec; x.e_ready = er;
        return x;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Frame result as seen through an aw-bit accumulator
    function automatic longint exp_acc(longint s, int aw);
        longint lim = longint'(1) << aw;
`ifdef ACCUM_SATURATE_EN
        return (s >= lim) ? lim - 1 : s;
`else
        return s % lim;
`endif
    endfunction

    task automatic model_edge();
        if (!rst_n || clr) begin
            m_done = 1'b0; m_cnt = 0; m_sum = 0;
        end else if (m_done) begin
            if (rdy_i) begin
                m_done = 1'b0; m_cnt = 0; m_sum = 0;
            end
        end else if (valid_i) begin
            m_sum += longint'({c_v, sum_v});
            m_cnt++;
            if (m_cnt == COUNT) m_done = 1'b1;
        end
    endtask

    task automatic check_model();
        logic er;
        er = !m_done && rst_n;
        chk("ready8", 32'(ready8), 32'(er));
        chk("valid8", 32'(valid8), 32'(m_done));
        chk("acc8",   32'(acc8),   32'(exp_acc(m_sum, 8)));
        chk("ovf8",   32'(ovf8),   32'(m_sum >= 256));
        chk("cnt8",   32'(cnt8),   32'(m_cnt));
        chk("ready6", 32'(ready6), 32'(er));
        chk("valid6", 32'(valid6), 32'(m_done));
        chk("acc6",   32'(acc6),   32'(exp_acc(m_sum, 6)));
        chk("ovf6",   32'(ovf6),   32'(m_sum >= 64));
        chk("cnt6",   32'(cnt6),   32'(m_cnt));
    endtask

    task automatic drive(input logic r, input logic cl, input logic v,
                         input logic [4:0] s, input logic ri);
        rst_n = r; clr = cl; valid_i = v; {c_v, sum_v} = s; rdy_i = ri;
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check_model();
    endtask

    initial begin
        logic [6:0] gap;
        drive(1'b0, 1'b0, 1'b0, 5'h00, 1'b0);

        //          rst clr vld smp    rdy  eV  eAcc  eO  eC  eR
        vt[0]  = mk(0,  0,  0,  5'h00, 0,   0,  8'h00, 0, 0,  0);
        vt[1]  = mk(0,  0,  0,  5'h00, 0,   0,  8'h00, 0, 0,  0);
        vt[2]  = mk(1,  0,  0,  5'h00, 0,   0,  8'h00, 0, 0,  1);
        vt[3]  = mk(1,  0,  1,  5'h03, 0,   0,  8'h03, 0, 1,  1);
        vt[4]  = mk(1,  0,  1,  5'h05, 0,   0,  8'h08, 0, 2,  1);
        vt[5]  = mk(1,  0,  1,  5'h1F, 0,   0,  8'h27, 0, 3,  1);
        vt[6]  = mk(1,  0,  1,  5'h01, 0,   1,  8'h28, 0, 4,  0);
        vt[7]  = mk(1,  0,  1,  5'h1F, 0,   1,  8'h28, 0, 4,  0);
        vt[8]  = mk(1,  0,  0,  5'h1F, 0,   1,  8'h28, 0, 4,  0);
        vt[9]  = mk(1,  0,  1,  5'h1F, 0,   1,  8'h28, 0, 4,  0);
        vt[10] = mk(1,  0,  0,  5'h1F, 0,   1,  8'h28, 0, 4,  0);
        vt[11] = mk(1,  0,  1,  5'h1F, 0,   1,  8'h28, 0, 4,  0);
        vt[12] = mk(1,  0,  0,  5'h00, 1,   0,  8'h00, 0, 0,  1);

        // Reset, nominal frame and backpressure from the table
        for (int i = 0; i < 13; i++) begin
            drive(vt[i].rst_n, vt[i].clr, vt[i].valid, vt[i].smp, vt[i].rdy);
            step();
            chk($sformatf("tbl%0d_valid", i), 32'(valid8), 32'(vt[i].e_valid));
            chk($sformatf("tbl%0d_acc", i),   32'(acc8),   32'(vt[i].e_acc));
            chk($sformatf("tbl%0d_ovf", i),   32'(ovf8),   32'(vt[i].e_ovf));
            chk($sformatf("tbl%0d_cnt", i),   32'(cnt8),   32'(vt[i].e_cnt));
            chk($sformatf("tbl%0d_ready", i), 32'(ready8), 32'(vt[i].e_ready));
        end

        // Overflow: 4 x 0x1F = 0x7C, beyond 6 bits
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b0, 1'b1, 5'h1F, 1'b0);
            step();
        end
        chk("ovf_valid6", 32'(valid6), 32'(1));
`ifdef ACCUM_SATURATE_EN
        chk("ovf_acc6", 32'(acc6), 32'h3F);
`else
        chk("ovf_acc6", 32'(acc6), 32'h3C);
`endif
        chk("ovf_flag6", 32'(ovf6), 32'(1));
        chk("ovf_acc8",  32'(acc8), 32'h7C);
        chk("ovf_flag8", 32'(ovf8), 32'(0));
        drive(1'b1, 1'b0, 1'b0, 5'h00, 1'b1);
        step();
        drive(1'b1, 1'b0, 1'b1, 5'h01, 1'b1);
        step();
        chk("next_frame_ovf6", 32'(ovf6), 32'(0));
        chk("next_frame_acc6", 32'(acc6), 32'h01);

        // Clear after two samples, offered sample dropped
        drive(1'b1, 1'b1, 1'b0, 5'h00, 1'b0);
        step();
        drive(1'b1, 1'b0, 1'b1, 5'h03, 1'b0);
        step();
        drive(1'b1, 1'b0, 1'b1, 5'h05, 1'b0);
        step();
        drive(1'b1, 1'b1, 1'b1, 5'h1F, 1'b0);
        step();
        chk("clr_acc",   32'(acc8),   32'h00);
        chk("clr_cnt",   32'(cnt8),   32'(0));
        chk("clr_ready", 32'(ready8), 32'(1));
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b0, 1'b1, 5'h02, 1'b0);
            step();
        end
        chk("post_clr_acc",   32'(acc8),   32'h08);
        chk("post_clr_valid", 32'(valid8), 32'(1));
        drive(1'b1, 1'b0, 1'b0, 5'h00, 1'b1);
        step();

        // Gapped valid_in: result only after the 4th accept
        gap = 7'b1101001;  // applied LSB first: 1,0,0,1,0,1,1
        for (int i = 0; i < 7; i++) begin
            drive(1'b1, 1'b0, gap[i], 5'h01, 1'b0);
            step();
            if (i == 5) chk("gap_not_done", 32'(valid8), 32'(0));
        end
        chk("gap_valid", 32'(valid8), 32'(1));
        chk("gap_acc",   32'(acc8),   32'h04);
        drive(1'b1, 1'b0, 1'b0, 5'h00, 1'b1);
        step();

        // Reset mid-frame
        drive(1'b1, 1'b0, 1'b1, 5'h07, 1'b0);
        step();
        step();
        drive(1'b0, 1'b0, 1'b1, 5'h07, 1'b0);
        step();
        chk("midrst_acc",   32'(acc8),   32'h00);
        chk("midrst_cnt",   32'(cnt8),   32'(0));
        chk("midrst_ready", 32'(ready8), 32'(0));
        chk("midrst_valid", 32'(valid8), 32'(0));
        drive(1'b1, 1'b0, 1'b0, 5'h00, 1'b0);
        step();

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            drive(($urandom % 100) != 0, ($urandom % 40) == 0, ($urandom % 4) != 0,
                  5'($urandom), ($urandom % 3) != 0);
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
